// File: rtl/rdr_pkg.sv
// Shared definitions for the synapse row reader: state encoding, default sizes
// and the occupancy counter width.
package rdr_pkg;

    localparam int DEF_AW         = 8;
    localparam int DEF_DW         = 32;
    localparam int DEF_FIFO_DEPTH = 3;
    localparam int OCC_W          = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rdr_state_t;

endpackage

// File: rtl/rdr_fifo.sv
// Small synchronous FIFO carrying one RAM word plus its end-of-burst flag.
// Output is driven straight from storage and forced to zero while empty.
module rdr_fifo
    import rdr_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = DEF_DW + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic [OCC_W-1:0] count,
    output logic             not_empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [OCC_W-1:0] wr_ptr;
    logic [OCC_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [OCC_W-1:0] next_ptr(input logic [OCC_W-1:0] p);
        return (p == OCC_W'(DEPTH - 1)) ? '0 : p + OCC_W'(1);
    endfunction

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    assign pop_data  = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + OCC_W'(1);
            end else if (do_pop && !push) begin
                count <= count - OCC_W'(1);
            end
        end
    end

endmodule

// File: rtl/synapse_row_reader.sv
// Burst read initiator for one DFFRAM256x32 port, streaming words out over valid/ready.
// Define SYNAPSE_READER_BURST_WRAP_EN to let bursts wrap from address 255 to 0.
module synapse_row_reader
    import rdr_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_a,
    input  logic [DW-1:0] ram_do,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [1:0]    dbg_state
);

    rdr_state_t       state_q, state_d;
    logic [AW-1:0]    addr_q;
    logic [AW:0]      rem_q;
    logic             inflight_q;
    logic             inflight_last_q;
    logic             err_q;

    logic             accept;
    logic             reject;
    logic             issue;
    logic             drained;
    logic             range_bad;
    logic             has_room;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   pending;
    logic             fifo_nonempty;
    logic [DW:0]      fifo_out;

`ifdef SYNAPSE_READER_BURST_WRAP_EN
    assign range_bad = 1'b0;
`else
    logic [AW+1:0] end_addr;
    assign end_addr  = {2'b00, base_addr} + {1'b0, len};
    // Anything past 2**AW words would wrap the address.
    assign range_bad = end_addr[AW+1] || (end_addr[AW] && (end_addr[AW-1:0] != '0));
`endif

    // Occupancy is taken before this cycle's pop, so a word still in the RAM
    // pipeline always finds a free slot when it lands.
    assign pending  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
    assign has_room = (pending < (OCC_W + 1)'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        issue   = 1'b0;
        drained = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((len == '0) || range_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (rem_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    issue = has_room;
                end
            end
            ST_DRAIN: begin
                if (!fifo_nonempty && !inflight_q) begin
                    drained = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_q           <= reject;
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_q == (AW + 1)'(1));
            if (accept) begin
                addr_q <= base_addr;
                rem_q  <= len;
            end else if (issue) begin
                addr_q <= addr_q + AW'(1);
                rem_q  <= rem_q - (AW + 1)'(1);
            end
        end
    end

    // Stream: a word moves on m_valid && m_ready; while stalled the head entry
    // is held unchanged and m_valid stays high until it is taken.
    rdr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DW + 1)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (inflight_q),
        .push_data ({inflight_last_q, ram_do}),
        .pop       (m_ready),
        .pop_data  (fifo_out),
        .count     (occ),
        .not_empty (fifo_nonempty)
    );

    assign busy      = (state_q == ST_READ) || ((state_q == ST_DRAIN) && !drained);
    assign done      = drained;
    assign err       = err_q;
    assign ram_en    = issue;
    assign ram_we    = 4'b0000;
    assign ram_a     = addr_q;
    assign m_valid   = fifo_nonempty;
    assign m_data    = fifo_out[DW-1:0];
    assign m_last    = fifo_out[DW];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_synapse_row_reader.sv
// Directed bench for synapse_row_reader with a behavioural DFFRAM read port.
module tb_synapse_row_reader;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy, done, err, ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_do = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    dbg_state;

    synapse_row_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_do    (ram_do),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM model ----------------
    logic [DW-1:0] ram [256];
    always @(posedge CLK) ram_do <= ram_en ? ram[ram_a] : '0;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [DW:0] exp_q[$];
    int          outstanding = 0;
    int          issue_total = 0;
    int          hs_total    = 0;
    int          done_count  = 0;
    int          done_cyc    = 0;
    int          last_cyc    = 0;
    logic        prev_stall  = 1'b0;
    logic [DW:0] prev_word   = '0;

    always @(negedge CLK) begin
        logic [63:0] exp_word;
        if (RST) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_word", 64'({m_last, m_data}), 64'(prev_word));
            end
            if (ram_en) begin
                check("issue_cap", 64'(outstanding < 3), 64'(1));
                check("ram_we", 64'(ram_we), 64'(0));
                issue_total++;
            end
            if (m_valid && m_ready) begin
                hs_total++;
                exp_word = (exp_q.size() != 0) ? 64'(exp_q.pop_front()) : 'x;
                check("stream_word", 64'({m_last, m_data}), exp_word);
                if (m_last) last_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            outstanding += int'(ram_en) - int'(m_valid && m_ready);
        end
    end

    // ---------------- sink ready pattern ----------------
    int ready_mode = 0;
    int rcnt       = 0;
    always @(posedge CLK) begin
        #1;
        if (ready_mode == 0) begin
            m_ready = 1'b1;
        end else begin
            m_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            rcnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        @(posedge CLK); #1;
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(posedge CLK); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0 = done_count;
        int n  = 0;
        while (done_count == d0 && n < bound) begin
            @(posedge CLK); #1;
            n++;
        end
        check({tag, "_done"}, 64'(done_count - d0), 64'(1));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic push_burst(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back({(i == l - 1), 32'(((b + i) % 256) * 3)});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_ram_en"}, 64'(ram_en), 64'(0));
        check({tag, "_ram_a"}, 64'(ram_a), 64'(0));
        check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
        check({tag, "_m_data"}, 64'(m_data), 64'(0));
        check({tag, "_m_last"}, 64'(m_last), 64'(0));
        check({tag, "_state"}, 64'(dbg_state), 64'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int i0;
        int h0;
        int d0;

        for (int i = 0; i < 256; i++) ram[i] = 32'(i * 3);
        RST       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b0;

        // Burst 1: base 0x10, len 4, sink always ready
        exp_q.push_back({1'b0, 32'h30});
        exp_q.push_back({1'b0, 32'h33});
        exp_q.push_back({1'b0, 32'h36});
        exp_q.push_back({1'b1, 32'h39});
        do_start(8'h10, 9'd4);
        check("t1_busy", 64'(busy), 64'(1));
        n = 0;
        while (!m_valid && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("t1_latency", 64'(n), 64'(2));
        wait_done("t1", 40);
        check("t1_done_after_last", 64'(done_cyc - last_cyc), 64'(1));
        check("t1_idle_busy", 64'(busy), 64'(0));

        // Burst 2: base 0, len 8, sink toggles 1,0,0,1
        ready_mode = 1;
        rcnt       = 0;
        push_burst(0, 8);
        do_start(8'h00, 9'd8);
        wait_done("t2", 120);
        ready_mode = 0;
        repeat (2) @(posedge CLK);
        #1;

        // len = 0 is rejected
        i0 = issue_total;
        do_start(8'h10, 9'd0);
        check("t3_err", 64'(err), 64'(1));
        check("t3_busy", 64'(busy), 64'(0));
        @(posedge CLK); #1;
        check("t3_err_pulse", 64'(err), 64'(0));
        repeat (3) @(posedge CLK);
        #1;
        check("t3_no_reads", 64'(issue_total - i0), 64'(0));

        // base 0xFE, len 4 crosses the top of the RAM
        i0 = issue_total;
`ifdef SYNAPSE_READER_BURST_WRAP_EN
        exp_q.push_back({1'b0, 32'h2FA});
        exp_q.push_back({1'b0, 32'h2FD});
        exp_q.push_back({1'b0, 32'h000});
        exp_q.push_back({1'b1, 32'h003});
        do_start(8'hFE, 9'd4);
        wait_done("t4_wrap", 40);
        check("t4_wrap_reads", 64'(issue_total - i0), 64'(4));
`else
        do_start(8'hFE, 9'd4);
        check("t4_err", 64'(err), 64'(1));
        check("t4_busy", 64'(busy), 64'(0));
        @(posedge CLK); #1;
        check("t4_err_pulse", 64'(err), 64'(0));
        repeat (3) @(posedge CLK);
        #1;
        check("t4_no_reads", 64'(issue_total - i0), 64'(0));
`endif

        // Full-range burst base 0, len 256 is accepted
        push_burst(0, 256);
        do_start(8'h00, 9'd256);
        wait_done("t_full", 400);

        // Reset in the middle of a len=16 burst
        push_burst(8'h20, 16);
        h0 = hs_total;
        do_start(8'h20, 9'd16);
        n = 0;
        while ((hs_total - h0) < 2 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        check("t5_two_words", 64'(hs_total - h0), 64'(2));
        RST = 1'b1;
        d0  = done_count;
        @(posedge CLK); #1;
        check_reset_outputs("t5_abort");
        RST = 1'b0;
        exp_q.delete();
        h0 = hs_total;
        repeat (4) @(posedge CLK);
        #1;
        check("t5_fifo_empty", 64'(hs_total - h0), 64'(0));
        check("t5_no_done", 64'(done_count - d0), 64'(0));
        push_burst(0, 1);
        do_start(8'h00, 9'd1);
        wait_done("t5_after", 40);

        // start while busy is ignored
        push_burst(8'h40, 4);
        h0 = hs_total;
        i0 = issue_total;
        do_start(8'h40, 9'd4);
        do_start(8'h80, 9'd2);
        check("t6_no_err", 64'(err), 64'(0));
        wait_done("t6", 40);
        repeat (5) @(posedge CLK);
        #1;
        check("t6_words", 64'(hs_total - h0), 64'(4));
        check("t6_reads", 64'(issue_total - i0), 64'(4));
        check("t6_idle_state", 64'(dbg_state), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/synapse_row_reader.md
Name: synapse_row_reader

Overview:
- Read-side initiator for one DFFRAM256x32 port in the neuron core.
- Takes a burst request (base address, length) and drives the RAM's EN0/WE0/A0 pins.
- Captures Do0 exactly one cycle after each enabled read and streams the words to the neuron datapath over a valid/ready interface.
- Keeps full throughput under backpressure. RAM Do0 returns 0 whenever EN0 is low, so every read must be captured in the cycle it returns.

Parameters:
- AW, 8, RAM address width (256 words).
- DW, 32, RAM data width.
- FIFO_DEPTH, 3, output buffer entries. The minimum for 1 word/cycle under the issue rule below.

Ports:
- CLK  in  1  Single clock, shared with the RAM.
- RST  in  1  Reset, synchronous, active-high.
- start  in  1  Request strobe. Sampled only in IDLE.
- base_addr  in  AW  First word address.
- len  in  AW+1  Word count, valid range 1..256.
- busy  out  1  High while a burst is in progress.
- done  out  1  One-cycle pulse on burst completion.
- err  out  1  One-cycle pulse when a request is rejected.
- ram_en  out  1  To RAM EN0.
- ram_we  out  4  To RAM WE0. Tied to 4'b0000.
- ram_a  out  AW  To RAM A0.
- ram_do  in  DW  From RAM Do0.
- m_valid  out  1  Stream word available.
- m_ready  in  1  Sink accepts the word.
- m_data  out  DW  Stream word.
- m_last  out  1  High with the final word of the burst.

Behaviour:
- Reset values: busy=0, done=0, err=0, ram_en=0, ram_a=0, m_valid=0, m_data=0, m_last=0. FIFO is emptied, in-flight flag cleared, state=IDLE.
- Reset mid-burst: abort immediately. The word returning next cycle is discarded. No done pulse.
- FSM states:
  - IDLE: on start with a valid request, latch addr=base_addr and remaining=len, go to READ. Set busy the next cycle.
  - READ: issue reads until remaining==0, then go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to IDLE. done=1 for that single cycle; busy=0 the same cycle.
- Issue rule, evaluated in READ: ram_en=1 iff remaining>0 and (occupancy + inflight) < FIFO_DEPTH. Occupancy is sampled before any pop in this cycle.
- On each issue: ram_a=addr, addr increments by 1, remaining decrements by 1, inflight is set for the next cycle.
- Capture: in the cycle after an issue, ram_do is pushed into the FIFO unconditionally. Space is guaranteed by the issue rule.
- Latency: first word is visible on m_valid 2 cycles after start is accepted. With m_ready held high, throughput is 1 word/cycle.
- Stream rules:
  - A word transfers on m_valid && m_ready.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
- m_last is tagged on the FIFO entry corresponding to the read issued when remaining was 1.
- Push and pop in the same cycle: occupancy is unchanged.
- start while busy is ignored: no err, no effect.
- len=0: err pulse, stay in IDLE, no RAM access.
- Range check: if base_addr+len > 256, the behaviour depends on BURST_WRAP_EN (below).

Optional Feature:
- Macro: SYNAPSE_READER_BURST_WRAP_EN.
- Defined: addr wraps modulo 256 (255 → 0), so any len in 1..256 is accepted from any base.
- Undefined: a request with base_addr+len > 256 pulses err for one cycle and stays in IDLE with no RAM access. addr never wraps.

Decomposition:
- Package rdr_pkg holds:
  - the state encoding (IDLE=2'd0, READ=2'd1, DRAIN=2'd2);
  - AW, DW and FIFO_DEPTH defaults;
  - the width of the occupancy counter (2 bits).
- One sub-module, rdr_fifo: a DEPTH x (DW+1) synchronous FIFO carrying data plus the last flag. It has push/pop/occupancy and is reset by the same RST.
- FSM, address/remaining counters and issue logic stay in the top.

Test Plan:
- Pre-load RAM[i]=i*3; start base=0x10, len=4, m_ready=1 → m_data 0x30, 0x33, 0x36, 0x39 on 4 consecutive cycles. First m_valid 2 cycles after start; m_last on 0x39; done pulse the cycle after; ram_we=0 throughout.
- base=0x00, len=8, m_ready toggling 1,0,0,1,... → all 8 words delivered in order, none lost or duplicated. ram_en is never high while occupancy+inflight=3; data held stable while stalled.
- len=0 → err pulse, busy stays 0, ram_en never asserted.
- base=0xFE, len=4: macro undefined → err pulse, no reads. Macro defined → addresses FE, FF, 00, 01 read, done pulse.
- Assert RST during word 3 of a len=16 burst → next cycle all outputs at reset values, FIFO empty, no done. A following start base=0, len=1 completes normally.
- start pulsed again while busy → ignored; only the first burst's words appear.
